alu_acc_ctrl: RTL and testbench
===============================

Name: alu_acc_ctrl

Overview:
Sequencing and accumulator stage wrapped around the 16-bit combinational ALU (4-bit op select, 16-bit a/b, 16-bit out plus carry).
- Buffers incoming operation commands in a small FIFO and issues them to the ALU one at a time.
- Registers each ALU result and carry into an accumulator that later commands can use as operand a.
- Returns each result with status flags over a valid/ready response handshake.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
PTR_W, 2, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
cmd_valid  input  1  command offered.
cmd_ready  output  1  FIFO can accept; equals (count != FIFO_DEPTH).
cmd_op  input  4  ALU operation code, passed unchanged to alu_sel.
cmd_a  input  16  explicit operand a.
cmd_b  input  16  operand b.
cmd_use_acc  input  1  1: operand a = accumulator; 0: operand a = cmd_a.
acc_clr  input  1  synchronous accumulator clear.
alu_a  output  16  registered operand a to ALU.
alu_b  output  16  registered operand b to ALU.
alu_sel  output  4  registered op code to ALU.
alu_out  input  16  ALU result.
alu_carry  input  1  ALU carry / bit 16 of result.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  16  captured result.
rsp_carry  output  1  captured carry.
rsp_zero  output  1  rsp_data == 0.
rsp_dz  output  1  divide-by-zero flag.
acc_q  output  16  current accumulator value.
stat_ops  output  16  completed-operation counter (see Optional Feature).
stat_dz  output  8  divide-by-zero counter (see Optional Feature).

Behaviour:
Reset (rst_n low at clock edge):
- FIFO empty, pointers 0, state IDLE.
- acc_q, alu_a, alu_b, rsp_data: 0. alu_sel: 4'b0000.
- rsp_valid, rsp_carry, rsp_zero, rsp_dz: 0.
- Reset mid-operation discards all queued and in-flight commands; no response is produced for them.

FIFO:
- Push when cmd_valid && cmd_ready.
- Pointers wrap modulo FIFO_DEPTH.
- cmd_ready is low whenever full, even if a pop occurs in the same cycle; no full-bypass.
- Simultaneous push and pop when not full: count unchanged.

FSM (IDLE -> ISSUE -> RESP -> IDLE):
- IDLE: if FIFO non-empty, pop the head and register the ALU inputs: alu_a = (cmd_use_acc ? acc_q : cmd_a), alu_b = cmd_b, alu_sel = cmd_op. Next state ISSUE. Otherwise stay in IDLE.
- ISSUE: the ALU settles combinationally. At the clock edge, capture rsp_data = alu_out, rsp_carry = alu_carry, rsp_zero = (alu_out == 0), and acc_q = alu_out. Next state RESP.
- RESP: rsp_valid = 1 and response fields held stable. When rsp_ready = 1, go to IDLE with rsp_valid cleared at that edge. While rsp_ready = 0, stay in RESP.

Divide by zero (alu_sel == 4'b0011 and alu_b == 0), in ISSUE:
- rsp_data = 16'hFFFF, rsp_carry = 0, rsp_zero = 0, rsp_dz = 1.
- acc_q is not updated.
- For all other ops, rsp_dz = 0.

Latency and throughput:
- A command accepted in cycle 0 with the FIFO empty and state IDLE produces rsp_valid in cycle 3.
- Maximum throughput is one command per 3 cycles when rsp_ready is held high.

Accumulator:
- A cmd_use_acc command always sees the result of the immediately preceding completed, non-dz command.
- acc_clr sets acc_q to 0 at the clock edge. If acc_clr coincides with the ISSUE capture, the clear wins (acc_q = 0); rsp_data still reflects alu_out.
- acc_clr does not affect the FIFO or the FSM.

Optional Feature:
Macro: ALU_ACC_CTRL_STATS_EN
- Defined:
  - stat_ops increments by 1 on each ISSUE capture, wrapping 16'hFFFF -> 0.
  - stat_dz increments on each dz capture and saturates at 8'hFF.
  - Both counters are 0 after reset.
- Undefined: stat_ops and stat_dz are tied to constant 0 and no counter flops are built.

Test Plan:
- Reset with rst_n = 0 for 2 cycles while cmd_valid = 1 -> all outputs 0, cmd_ready = 1 after release, no response.
- cmd op=0000, a=16'h0003, b=16'h0004, use_acc=0, rsp_ready=1 -> rsp_valid in cycle 3, rsp_data=16'h0007, rsp_carry=0, rsp_zero=0, acc_q=16'h0007.
- Chain: op=0000, a=16'hFFFF, b=16'h0001, then op=0100 with use_acc=1 -> first response data=0, carry=1, zero=1; second response data=16'h0001.
- op=0011, a=16'h0010, b=0 -> rsp_data=16'hFFFF, rsp_dz=1, acc_q unchanged; with macro, stat_dz=1.
- Hold rsp_ready=0 and push 5 commands with FIFO_DEPTH=4 -> 1 command in flight plus 4 queued, cmd_ready=0; release rsp_ready -> 5 responses in order, none lost or duplicated.
- Assert acc_clr in the same cycle as the ISSUE capture of op=0111, a=16'h00F0, b=16'h000F -> rsp_data=16'h00FF, acc_q=0.

Source files
------------

// File: rtl/alu_acc_ctrl.sv
// Command FIFO, issue FSM and accumulator wrapped around an external 16-bit combinational ALU.
// Optional statistics counters are built only when ALU_ACC_CTRL_STATS_EN is defined.
module alu_acc_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_use_acc,
  input  logic        acc_clr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_dz,
  output logic [15:0] acc_q,
  output logic [15:0] stat_ops,
  output logic [7:0]  stat_dz
);

  localparam int         CNT_W  = PTR_W + 1;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  cmd_t        r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_sel;
  logic [15:0] r_rsp_data;
  logic        r_rsp_carry;
  logic        r_rsp_zero;
  logic        r_rsp_dz;
  logic [15:0] r_acc;

  logic        w_push;
  logic        w_pop;
  logic        w_capture;
  logic        w_dz;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  cmd_t        w_push_word;
  cmd_t        w_head;

  // ------------------------------------------------------------------
  // Command FIFO
  // ------------------------------------------------------------------
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready    = !w_fifo_full;
  assign w_push       = cmd_valid && !w_fifo_full;
  assign w_head       = r_fifo_mem[r_rd_ptr];

  always_comb begin
    w_push_word         = '0;
    w_push_word.op      = cmd_op;
    w_push_word.a       = cmd_a;
    w_push_word.b       = cmd_b;
    w_push_word.use_acc = cmd_use_acc;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Issue FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_capture    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Operand, response and accumulator registers
  // ------------------------------------------------------------------
  assign w_dz = (r_alu_sel == OP_DIV) && (r_alu_b == 16'h0000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 4'b0000;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_dz    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a   <= w_head.use_acc ? r_acc : w_head.a;
        r_alu_b   <= w_head.b;
        r_alu_sel <= w_head.op;
      end
      if (w_capture) begin
        if (w_dz) begin
          r_rsp_data  <= 16'hFFFF;
          r_rsp_carry <= 1'b0;
          r_rsp_zero  <= 1'b0;
          r_rsp_dz    <= 1'b1;
        end else begin
          r_rsp_data  <= alu_out;
          r_rsp_carry <= alu_carry;
          r_rsp_zero  <= (alu_out == 16'h0000);
          r_rsp_dz    <= 1'b0;
        end
      end
    end
  end

  // A clear coinciding with a capture wins over the captured result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_capture && !w_dz) begin
      r_acc <= alu_out;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_dz    = r_rsp_dz;
  assign acc_q     = r_acc;

  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------
`ifdef ALU_ACC_CTRL_STATS_EN
  logic [15:0] r_stat_ops;
  logic [7:0]  r_stat_dz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_ops <= '0;
      r_stat_dz  <= '0;
    end else if (w_capture) begin
      r_stat_ops <= r_stat_ops + 1'b1;
      if (w_dz && (r_stat_dz != 8'hFF)) begin
        r_stat_dz <= r_stat_dz + 1'b1;
      end
    end
  end

  assign stat_ops = r_stat_ops;
  assign stat_dz  = r_stat_dz;
`else
  assign stat_ops = 16'h0000;
  assign stat_dz  = 8'h00;
`endif

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench for alu_acc_ctrl: a behavioural ALU closes the loop, vectors are checked from a table.
module tb_alu_acc_ctrl;

`ifdef ALU_ACC_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_use_acc;
  logic        acc_clr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_dz;
  logic [15:0] acc_q;
  logic [15:0] stat_ops;
  logic [7:0]  stat_dz;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;
  int exp_dz = 0;

  alu_acc_ctrl #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_dz(rsp_dz),
    .acc_q(acc_q), .stat_ops(stat_ops), .stat_dz(stat_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, mul, div, inc, or.
  logic [16:0] alu_res;
  logic [31:0] prod;
  always_comb begin
    prod    = 32'(alu_a) * 32'(alu_b);
    alu_res = 17'h0;
    case (alu_sel)
      4'b0000: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: alu_res = prod[16:0];
      4'b0011: alu_res = (alu_b == 16'h0) ? 17'h0 : {1'b0, alu_a / alu_b};
      4'b0100: alu_res = {1'b0, alu_a} + 17'h1;
      4'b0111: alu_res = {1'b0, alu_a | alu_b};
      default: alu_res = 17'h0;
    endcase
  end
  assign alu_out   = alu_res[15:0];
  assign alu_carry = alu_res[16];

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
    logic        clr;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        dz;
    logic [15:0] acc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic ua);
    int n;
    n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int n;
    v = vecs[idx];
    rsp_ready = 1'b1;
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_use_acc = v.use_acc; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      acc_clr = (n == 2) ? v.clr : 1'b0;
      @(posedge clk); #1; n++;
    end
    acc_clr = 1'b0;
    exp_ops++;
    if (v.dz) exp_dz++;
    $display("vec %0d: op=%h a=%h b=%h use_acc=%0b clr=%0b -> data=%h carry=%0b zero=%0b dz=%0b acc=%h lat=%0d",
             idx, v.op, v.a, v.b, v.use_acc, v.clr, rsp_data, rsp_carry, rsp_zero, rsp_dz, acc_q, n);
    chk($sformatf("vec%0d_latency", idx), 32'(n), 32'd3);
    chk($sformatf("vec%0d_data", idx), 32'(rsp_data), 32'(v.data));
    chk($sformatf("vec%0d_carry", idx), 32'(rsp_carry), 32'(v.carry));
    chk($sformatf("vec%0d_zero", idx), 32'(rsp_zero), 32'(v.zero));
    chk($sformatf("vec%0d_dz", idx), 32'(rsp_dz), 32'(v.dz));
    chk($sformatf("vec%0d_acc", idx), 32'(acc_q), 32'(v.acc));
    @(posedge clk); #1;
    chk($sformatf("vec%0d_valid_drop", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    //             op     a         b         ua    clr   data      c     z     dz    acc
    vecs[0] = '{4'h0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0007};
    vecs[1] = '{4'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{4'h4, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[3] = '{4'h3, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[4] = '{4'h4, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0002};
    vecs[5] = '{4'h7, 16'h00F0, 16'h000F, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{4'h1, 16'h5555, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[7] = '{4'h3, 16'h0000, 16'h0010, 1'b1, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h0FFF};
    vecs[8] = '{4'h2, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 16'h1111; cmd_b = 16'h2222;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;

    // Reset held two cycles with a command offered
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp", {rsp_data, 12'h0, rsp_valid, rsp_carry, rsp_zero, rsp_dz}, 32'd0);
    chk("rst_acc", 32'(acc_q), 32'd0);
    chk("rst_stats", {stat_ops, stat_dz, 8'h0}, 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("rst_no_rsp", 32'(seen), 32'd0);
    end
    $display("reset: cmd_ready=%0b acc=%h", cmd_ready, acc_q);

    for (int i = 0; i < 9; i++) begin
      run_vec(i);
    end

    // Backpressure: one command in flight plus a full FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(4'h0, 16'h0100 + 16'(i), 16'(i), 1'b0);
      $display("bp push %0d: cmd_ready=%0b", i, cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    chk("bp_held_valid", 32'(rsp_valid), 32'd1);
    chk("bp_held_data", 32'(rsp_data), 32'h0100);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp($sformatf("bp_rsp%0d_timeout", i));
      $display("bp rsp %0d: data=%h", i, rsp_data);
      chk($sformatf("bp_rsp%0d_data", i), 32'(rsp_data), 32'h0100 + 32'(2 * i));
      exp_ops++;
      @(posedge clk); #1;
    end
    begin
      int extra;
      extra = 0;
      repeat (6) begin
        if (rsp_valid) extra++;
        @(posedge clk); #1;
      end
      chk("bp_no_dup", 32'(extra), 32'd0);
    end
    chk("bp_ready_again", 32'(cmd_ready), 32'd1);
    chk("stat_ops", 32'(stat_ops), STATS ? 32'(exp_ops) : 32'd0);
    chk("stat_dz", 32'(stat_dz), STATS ? 32'(exp_dz) : 32'd0);
    $display("stats: ops=%0d dz=%0d", stat_ops, stat_dz);

    // Reset mid-operation discards queued and in-flight commands
    rsp_ready = 1'b0;
    push_cmd(4'h0, 16'h0AAA, 16'h0001, 1'b0);
    push_cmd(4'h0, 16'h0BBB, 16'h0001, 1'b0);
    wait_rsp("mid_rsp_timeout");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("mid_rst_no_rsp", 32'(seen), 32'd0);
    end
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_acc", 32'(acc_q), 32'd0);
    chk("mid_rst_stats", {stat_ops, stat_dz, 8'h0}, 32'd0);
    $display("mid reset: rsp_valid=%0b acc=%h", rsp_valid, acc_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
